// File: rtl/paj7620_pkg.sv
// ============================================================================
// Module      : paj7620_pkg
// Description : Shared types and constants for the PAJ7620 I2C responder model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package paj7620_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_REG       = 4'd3,
        ST_REG_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RACK      = 4'd8
    } state_t;

    localparam logic [7:0] REG_PID_L     = 8'h00;
    localparam logic [7:0] REG_PID_H     = 8'h01;
    localparam logic [7:0] REG_INT_FLAG1 = 8'h43;
    localparam logic [7:0] REG_INT_FLAG2 = 8'h44;
    localparam logic [7:0] REG_BANK_SEL  = 8'hEF;

    localparam int UP    = 0;
    localparam int DOWN  = 1;
    localparam int LEFT  = 2;
    localparam int RIGHT = 3;
    localparam int FWD   = 4;
    localparam int BWD   = 5;
    localparam int CW    = 6;
    localparam int CCW   = 7;
    localparam int WAVE  = 8;

endpackage

`default_nettype wire

// File: rtl/paj7620_i2c_responder_sync.sv
// ============================================================================
// Module      : i2c_bus_sync
// Description : SCL/SDA synchronizers with registered rise/fall/START/STOP pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sda
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic                   r_scl_rise;
    logic                   r_scl_fall;
    logic                   r_start;
    logic                   r_stop;
    logic                   w_scl;
    logic                   w_sda;

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    // r_sda_d is the SDA level aligned with the registered edge pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
            r_scl_rise <= w_scl & ~r_scl_d;
            r_scl_fall <= ~w_scl & r_scl_d;
            r_start    <= w_scl & r_scl_d & r_sda_d & ~w_sda;
            r_stop     <= w_scl & r_scl_d & ~r_sda_d & w_sda;
        end
    end

    assign o_scl_rise = r_scl_rise;
    assign o_scl_fall = r_scl_fall;
    assign o_start    = r_start;
    assign o_stop     = r_stop;
    assign o_sda      = r_sda_d;

endmodule

`default_nettype wire

// File: rtl/paj7620_i2c_responder.sv
// ============================================================================
// Module      : paj7620_i2c_responder
// Description : PAJ7620 gesture-sensor I2C target model with injectable flags.
//               Optional macro PAJ_WAKEUP_NACK_EN: NACK first matching address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module paj7620_i2c_responder
    import paj7620_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = 7'h73,
    parameter logic [15:0] PART_ID     = 16'h7620,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [8:0] gest_set,
    output logic       bank,
    output logic       busy
);

    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;
    logic       w_addr_hit, w_awake, w_load;
    logic [7:0] w_rd_byte, w_clr_lo;
    logic       w_clr_wave;

    state_t     r_state;
    logic [3:0] r_bitcnt;
    logic [7:0] r_shift;
    logic [7:0] r_ptr;
    logic       r_rw;
    logic       r_bank;
    logic       r_busy;
    logic       r_sda_oe;
    logic [7:0] r_flag_lo;
    logic       r_flag_wave;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .i_scl      (scl_in),
        .i_sda      (sda_in),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop),
        .o_sda      (w_sda)
    );

`ifdef PAJ_WAKEUP_NACK_EN
    logic r_wake;
    assign w_awake = r_wake;
`else
    assign w_awake = 1'b1;
`endif

    assign w_addr_hit = (r_shift[7:1] == DEV_ADDR);

    always_comb begin
        w_rd_byte = 8'h00;
        if (r_ptr == REG_BANK_SEL) begin
            w_rd_byte = {7'b0, r_bank};
        end else if (!r_bank) begin
            case (r_ptr)
                REG_PID_L:     w_rd_byte = PART_ID[7:0];
                REG_PID_H:     w_rd_byte = PART_ID[15:8];
                REG_INT_FLAG1: w_rd_byte = r_flag_lo;
                REG_INT_FLAG2: w_rd_byte = {7'b0, r_flag_wave};
                default:       w_rd_byte = 8'h00;
            endcase
        end
    end

    // Byte loads into the shift register are the clear-on-read moments
    assign w_load = ~w_start & ~w_stop & w_scl_fall &
                    (((r_state == ST_ADDR_ACK) & r_rw) |
                     ((r_state == ST_RACK) & (r_bitcnt == 4'd1)));
    assign w_clr_lo   = (w_load && !r_bank && r_ptr == REG_INT_FLAG1) ? r_flag_lo : 8'h00;
    assign w_clr_wave = w_load && !r_bank && r_ptr == REG_INT_FLAG2;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_flag_lo   <= 8'h00;
            r_flag_wave <= 1'b0;
        end else begin
            r_flag_lo   <= (r_flag_lo & ~w_clr_lo) | gest_set[CCW:UP];
            r_flag_wave <= (r_flag_wave & ~w_clr_wave) | gest_set[WAVE];
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= 4'd0;
            r_shift  <= 8'h00;
            r_ptr    <= 8'h00;
            r_rw     <= 1'b0;
            r_bank   <= 1'b0;
            r_busy   <= 1'b0;
            r_sda_oe <= 1'b0;
`ifdef PAJ_WAKEUP_NACK_EN
            r_wake   <= 1'b0;
`endif
        end else if (w_start) begin
            r_state  <= ST_ADDR;
            r_bitcnt <= 4'd0;
            r_busy   <= 1'b1;
            r_sda_oe <= 1'b0;
        end else if (w_stop) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_sda_oe <= 1'b0;
        end else begin
            case (r_state)
                ST_ADDR, ST_REG, ST_WDATA: begin
                    if (w_scl_rise) begin
                        r_shift  <= {r_shift[6:0], w_sda};
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end else if (w_scl_fall && r_bitcnt == 4'd8) begin
                        r_bitcnt <= 4'd0;
                        if (r_state == ST_ADDR) begin
                            if (w_addr_hit && w_awake) begin
                                r_rw     <= r_shift[0];
                                r_sda_oe <= 1'b1;
                                r_state  <= ST_ADDR_ACK;
                            end else begin
                                r_state  <= ST_IDLE;
                            end
`ifdef PAJ_WAKEUP_NACK_EN
                            if (w_addr_hit) r_wake <= 1'b1;
`endif
                        end else if (r_state == ST_REG) begin
                            r_ptr    <= r_shift;
                            r_sda_oe <= 1'b1;
                            r_state  <= ST_REG_ACK;
                        end else begin
                            if (r_ptr == REG_BANK_SEL) r_bank <= r_shift[0];
                            r_ptr    <= r_ptr + 8'd1;
                            r_sda_oe <= 1'b1;
                            r_state  <= ST_WDATA_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        r_bitcnt <= 4'd0;
                        if (r_rw) begin
                            r_shift  <= w_rd_byte;
                            r_sda_oe <= ~w_rd_byte[7];
                            r_state  <= ST_RDATA;
                        end else begin
                            r_sda_oe <= 1'b0;
                            r_state  <= ST_REG;
                        end
                    end
                end
                ST_REG_ACK, ST_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        r_sda_oe <= 1'b0;
                        r_bitcnt <= 4'd0;
                        r_state  <= ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (w_scl_rise) begin
                        r_bitcnt <= r_bitcnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bitcnt == 4'd8) begin
                            r_sda_oe <= 1'b0;
                            r_bitcnt <= 4'd0;
                            r_state  <= ST_RACK;
                        end else begin
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_sda_oe <= ~r_shift[6];
                        end
                    end
                end
                ST_RACK: begin
                    // bitcnt==1 marks a master ACK awaiting the next SCL fall
                    if (w_scl_rise) begin
                        if (!w_sda) begin
                            r_ptr    <= r_ptr + 8'd1;
                            r_bitcnt <= 4'd1;
                        end else begin
                            r_state  <= ST_IDLE;
                        end
                    end else if (w_scl_fall && r_bitcnt == 4'd1) begin
                        r_shift  <= w_rd_byte;
                        r_sda_oe <= ~w_rd_byte[7];
                        r_bitcnt <= 4'd0;
                        r_state  <= ST_RDATA;
                    end
                end
                default: begin
                    r_sda_oe <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign sda_oe = r_sda_oe;
    assign bank   = r_bank;
    assign busy   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_paj7620_i2c_responder.sv
// ============================================================================
// Module      : tb_paj7620_i2c_responder
// Description : Directed I2C master bench with expected-value scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_paj7620_i2c_responder;

    localparam int c_sync = 2;
    localparam int c_q    = 8;

    logic       sys_clk  = 1'b0;
    logic       sys_rst  = 1'b0;
    logic       m_scl    = 1'b1;
    logic       m_sda    = 1'b1;
    logic [8:0] gest_set = 9'h000;
    logic       sda_oe, bank, busy;
    logic       w_sda_line;
    int         n_tests  = 0;
    int         n_fail   = 0;
    int         oe_cnt   = 0;
    logic [7:0] exp_q[$];
    string      tag_q[$];

    assign w_sda_line = m_sda & ~sda_oe;

    always #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) if (sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;

    paj7620_i2c_responder #(
        .DEV_ADDR    (7'h73),
        .PART_ID     (16'h7620),
        .SYNC_STAGES (c_sync)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .scl_in   (m_scl),
        .sda_in   (w_sda_line),
        .sda_oe   (sda_oe),
        .gest_set (gest_set),
        .bank     (bank),
        .busy     (busy)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic expect_val(input string tag, input logic [7:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [7:0] obs);
        string      t;
        logic [7:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %02h expected none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %02h expected %02h", t, obs, e);
            end
        end
    endtask

    // gest_set pulse p lands on the clock where the DUT acts on this bit's SCL fall
    task automatic bit_xfer(input logic b, input logic [8:0] p, output logic r);
        m_sda = b;
        tick(c_q);
        m_scl = 1'b1;
        tick(c_q);
        r = w_sda_line;
        tick(c_q);
        m_scl = 1'b0;
        tick(c_sync + 1);
        gest_set = p;
        tick(1);
        gest_set = 9'h000;
        tick(c_q - c_sync - 2);
    endtask

    task automatic i2c_start;
        m_sda = 1'b1; tick(c_q);
        m_scl = 1'b1; tick(c_q);
        m_sda = 1'b0; tick(c_q);
        m_scl = 1'b0; tick(c_q);
    endtask

    task automatic i2c_stop;
        m_sda = 1'b0; tick(c_q);
        m_scl = 1'b1; tick(c_q);
        m_sda = 1'b1; tick(c_q);
    endtask

    task automatic write_byte(input string tag, input logic [7:0] v,
                              input logic exp_ack, input logic [8:0] p);
        logic r;
        expect_val(tag, {7'b0, exp_ack});
        for (int i = 7; i >= 0; i--) bit_xfer(v[i], 9'h000, r);
        bit_xfer(1'b1, p, r);
        check({7'b0, r});
    endtask

    task automatic read_byte(input string tag, input logic [7:0] exp_v, input logic ack);
        logic       r;
        logic [7:0] d;
        expect_val(tag, exp_v);
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, 9'h000, r);
            d[i] = r;
        end
        bit_xfer(ack, 9'h000, r);
        check(d);
    endtask

    task automatic read_reg(input string tag, input logic [7:0] ptr,
                            input logic [7:0] exp_v, input logic [8:0] p);
        i2c_start;
        write_byte({tag, "_aw"}, 8'hE6, 1'b0, 9'h000);
        write_byte({tag, "_ptr"}, ptr, 1'b0, 9'h000);
        i2c_start;
        write_byte({tag, "_ar"}, 8'hE7, 1'b0, p);
        read_byte(tag, exp_v, 1'b1);
        i2c_stop;
    endtask

    task automatic pulse_gest(input logic [8:0] p);
        gest_set = p;
        tick(1);
        gest_set = 9'h000;
        tick(2);
    endtask

    task automatic wake_after_reset;
`ifdef PAJ_WAKEUP_NACK_EN
        i2c_start;
        write_byte("wake_nack", 8'hE6, 1'b1, 9'h000);
        i2c_stop;
`endif
    endtask

    initial begin
        int         oe_snap;
        logic       r;

        #1 sys_rst = 1'b1;
        tick(4);
        expect_val("rst_sda_oe", 8'h00); check({7'b0, sda_oe});
        expect_val("rst_bank", 8'h00);   check({7'b0, bank});
        expect_val("rst_busy", 8'h00);   check({7'b0, busy});
        sys_rst = 1'b0;
        tick(4);
        wake_after_reset;

        // bank-select write
        i2c_start;
        write_byte("w1_addr", 8'hE6, 1'b0, 9'h000);
        write_byte("w1_reg", 8'hEF, 1'b0, 9'h000);
        write_byte("w1_data", 8'h01, 1'b0, 9'h000);
        expect_val("w1_busy", 8'h01); check({7'b0, busy});
        i2c_stop;
        expect_val("w1_bank", 8'h01);      check({7'b0, bank});
        expect_val("w1_busy_stop", 8'h00); check({7'b0, busy});

        // bank 1: only 0xEF is mapped
        i2c_start;
        write_byte("b1_aw", 8'hE6, 1'b0, 9'h000);
        write_byte("b1_ptr", 8'hEF, 1'b0, 9'h000);
        i2c_start;
        write_byte("b1_ar", 8'hE7, 1'b0, 9'h000);
        read_byte("b1_ef", 8'h01, 1'b0);
        read_byte("b1_f0", 8'h00, 1'b1);
        i2c_stop;

        i2c_start;
        write_byte("b0_aw", 8'hE6, 1'b0, 9'h000);
        write_byte("b0_ptr", 8'hEF, 1'b0, 9'h000);
        write_byte("b0_data", 8'h00, 1'b0, 9'h000);
        i2c_stop;
        expect_val("b0_bank", 8'h00); check({7'b0, bank});

        // part ID burst read with repeated START
        i2c_start;
        write_byte("pid_aw", 8'hE6, 1'b0, 9'h000);
        write_byte("pid_ptr", 8'h00, 1'b0, 9'h000);
        i2c_start;
        write_byte("pid_ar", 8'hE7, 1'b0, 9'h000);
        read_byte("pid_lo", 8'h20, 1'b0);
        read_byte("pid_hi", 8'h76, 1'b1);
        expect_val("pid_busy_nack", 8'h01); check({7'b0, busy});
        i2c_stop;
        expect_val("pid_busy_stop", 8'h00); check({7'b0, busy});

        // pointer wrap 0xFF -> 0x00
        i2c_start;
        write_byte("wrap_aw", 8'hE6, 1'b0, 9'h000);
        write_byte("wrap_ptr", 8'hFF, 1'b0, 9'h000);
        i2c_start;
        write_byte("wrap_ar", 8'hE7, 1'b0, 9'h000);
        read_byte("wrap_ff", 8'h00, 1'b0);
        read_byte("wrap_00", 8'h20, 1'b1);
        i2c_stop;

        // clear-on-read flags
        pulse_gest(9'h004);
        read_reg("flag_first", 8'h43, 8'h04, 9'h000);
        read_reg("flag_clear", 8'h43, 8'h00, 9'h000);

        pulse_gest(9'h008);
        read_reg("flag_coinc", 8'h43, 8'h08, 9'h001);
        read_reg("flag_kept", 8'h43, 8'h01, 9'h000);

        pulse_gest(9'h100);
        read_reg("wave_first", 8'h44, 8'h01, 9'h000);
        read_reg("wave_clear", 8'h44, 8'h00, 9'h000);

        // foreign address is never acknowledged
        oe_snap = oe_cnt;
        i2c_start;
        write_byte("foreign_addr", 8'hA4, 1'b1, 9'h000);
        write_byte("foreign_data", 8'h00, 1'b1, 9'h000);
        i2c_stop;
        expect_val("foreign_oe", 8'h00); check((oe_cnt - oe_snap == 0) ? 8'h00 : 8'h01);
        i2c_start;
        write_byte("after_foreign", 8'hE6, 1'b0, 9'h000);
        write_byte("after_foreign_ptr", 8'h00, 1'b0, 9'h000);
        i2c_stop;

        // asynchronous reset while driving bit 4 (a zero) of 0x20
        i2c_start;
        write_byte("rr_aw", 8'hE6, 1'b0, 9'h000);
        write_byte("rr_ptr", 8'h00, 1'b0, 9'h000);
        i2c_start;
        write_byte("rr_ar", 8'hE7, 1'b0, 9'h000);
        for (int i = 0; i < 3; i++) bit_xfer(1'b1, 9'h000, r);
        m_sda = 1'b1;
        tick(c_q);
        expect_val("rd_bit4_oe", 8'h01); check({7'b0, sda_oe});
        m_scl = 1'b1;
        tick(2);
        sys_rst = 1'b1;
        #1;
        expect_val("rst_async_oe", 8'h00); check({7'b0, sda_oe});
        m_sda = 1'b1;
        tick(4);
        sys_rst = 1'b0;
        tick(4);
        expect_val("post_rst_busy", 8'h00); check({7'b0, busy});

`ifdef PAJ_WAKEUP_NACK_EN
        i2c_start;
        write_byte("post_rst_wake", 8'hE6, 1'b1, 9'h000);
        i2c_stop;
`endif
        i2c_start;
        write_byte("post_rst_ack", 8'hE6, 1'b0, 9'h000);
        i2c_stop;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
